timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 N_REQ, 4, number of requesters sharing the single count-to-100 timer.
REQ-002 WDOG_MAX, 120, cycles of cnt_en without timeout_in before a watchdog fault.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester timer request; level, held until done or abandoned.
REQ-006 timeout_in  input  1  TimeOut from the shared count-to-100 counter.
REQ-007 grant  output  N_REQ  one-hot owner of the timer; all-zero when idle.
REQ-008 done  output  N_REQ  one-cycle pulse to the owner on timer expiry.
REQ-009 abort  output  1  one-cycle pulse when the owner drops req before expiry.
REQ-010 cnt_en  output  1  count enable to the shared counter (drives CounterIn).
REQ-011 cnt_clr  output  1  one-cycle synchronous clear to the shared counter.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 wdog_err  output  1  sticky watchdog fault flag.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE, ABORT; all outputs registered.
REQ-015 IDLE: if req nonzero, select the winner round-robin, starting one past last_owner; register grant; pulse cnt_clr; go to LOAD.
REQ-016 LOAD: hold grant; cnt_clr low; cnt_en high from this cycle; go to RUN.
REQ-017 RUN: hold grant and cnt_en; if timeout_in=1, go to DONE; if req[owner]=0, go to ABORT.
REQ-018 If timeout_in=1 and req[owner]=0 in the same RUN cycle, timeout wins: go to DONE.
REQ-019 DONE: done[owner]=1 for exactly one cycle; grant=0; cnt_en=0; last_owner<=owner; go to IDLE.
REQ-020 ABORT: abort=1 for one cycle; cnt_clr=1; grant=0; cnt_en=0; last_owner<=owner; go to IDLE.
REQ-021 A new grant is issued no earlier than the cycle after DONE or ABORT, giving a 2-cycle minimum gap between grants.
REQ-022 Requests arriving while busy are ignored until IDLE; no queueing beyond the req levels.
REQ-023 Round-robin is a strict rotation over N_REQ; a requester that was just served is lowest priority next.
REQ-024 The watchdog counter is 8 bits. It clears on each LOAD and increments each RUN cycle.
REQ-025 If the watchdog counter reaches WDOG_MAX without timeout_in, set wdog_err, take the ABORT path, and saturate the counter (no wrap).
REQ-026 wdog_err clears only on rst.
REQ-027 timeout_in sampled in IDLE, LOAD, DONE or ABORT is ignored.

Reset
REQ-028 With rst=1 at a clock edge, the FSM goes to IDLE and last_owner is set to N_REQ-1, so requester 0 has first priority.
REQ-029 With rst=1 at a clock edge: grant=0, done=0, abort=0, cnt_en=0, busy=0, wdog_err=0, and the watchdog counter is 0.
REQ-030 rst=1 at a clock edge also forces cnt_clr=1, clearing the shared counter.
REQ-031 Reset asserted mid-RUN: no done or abort pulse is issued, and grant drops on the same edge.

Structure
REQ-032 A shared package holds the state encoding constants, N_REQ, WDOG_MAX and the count terminal value 99.
REQ-033 Round-robin selection is a sub-module, rr_picker: combinational, with inputs req and last_owner and outputs a one-hot winner and a valid flag.
REQ-034 The top level instantiates rr_picker and the FSM. The CountTo100 counter instance lives outside the block.

Verification
REQ-035 Single request, rst then req=0001 held: grant=0001 one cycle later; cnt_en high for 100 cycles; done=0001 one cycle after timeout_in; grant=0000.
REQ-036 Contention, req=1111 held continuously: grants follow the order 0001, 0010, 0100, 1000, 0001; each grant receives exactly one done pulse.
REQ-037 Abandon, req=0100 dropped 30 cycles into RUN: abort pulses once; cnt_clr pulses; done stays 0; busy=0 two cycles later.
REQ-038 Simultaneous events, timeout_in=1 and req[owner]=0 in the same cycle: done pulses and abort stays 0.
REQ-039 Watchdog, timeout_in tied 0: wdog_err=1 after 120 RUN cycles; abort pulses; wdog_err stays 1 until rst.
REQ-040 Mid-operation reset, rst pulsed at RUN cycle 50: all outputs take reset values; next grant goes to requester 0 when req=1001.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared constants and types for the timer arbiter: requester count, watchdog limit,
// shared counter terminal value and FSM state encoding.
package timer_arbiter_pkg;

  localparam int N_REQ        = 4;
  localparam int WDOG_MAX     = 120;
  localparam int WDOG_W       = 8;
  localparam int CNT_TERMINAL = 99;
  localparam int OWN_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  function automatic logic [OWN_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [OWN_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = OWN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Request/grant and shared-counter control bundle between the arbiter and its users.
interface timer_arbiter_if;
  import timer_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             timeout_in;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             abort;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             wdog_err;

  modport slave (
    input  req, timeout_in,
    output grant, done, abort, cnt_en, cnt_clr, busy, wdog_err
  );

  modport master (
    output req, timeout_in,
    input  grant, done, abort, cnt_en, cnt_clr, busy, wdog_err
  );

endinterface

// File: rtl/timer_arbiter_rr_picker.sv
// Combinational round-robin picker: the first active request found after last_owner
// (wrapping) wins, so the requester just served has lowest priority.
module rr_picker
  import timer_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [OWN_W-1:0] i_last_owner,
  output logic [N_REQ-1:0] o_winner,
  output logic             o_valid
);

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!o_valid && i_req[OWN_W'((int'(i_last_owner) + k) % N_REQ)]) begin
        o_winner[OWN_W'((int'(i_last_owner) + k) % N_REQ)] = 1'b1;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Arbitrates one shared count-to-100 timer among N_REQ requesters with a watchdog.
// Every output is registered together with the state it belongs to.
module timer_arbiter
  import timer_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  timer_arbiter_if.slave bus
);

  state_t            r_state, w_state_next;
  logic [N_REQ-1:0]  r_grant, w_grant_next;
  logic [N_REQ-1:0]  r_done, w_done_next;
  logic [N_REQ-1:0]  w_winner;
  logic              w_valid;
  logic              r_abort, w_abort_next;
  logic              r_cnt_en, w_cnt_en_next;
  logic              r_cnt_clr, w_cnt_clr_next;
  logic              r_busy, w_busy_next;
  logic              r_wdog_err, w_wdog_err_next;
  logic [OWN_W-1:0]  r_owner, w_owner_next;
  logic [OWN_W-1:0]  r_last_owner, w_last_owner_next;
  logic [WDOG_W-1:0] r_wdog, w_wdog_next, w_wdog_inc;
  logic              w_wdog_hit;

  rr_picker u_picker (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  assign w_wdog_inc = (r_wdog < WDOG_W'(WDOG_MAX)) ? r_wdog + WDOG_W'(1) : r_wdog;
  assign w_wdog_hit = (w_wdog_inc == WDOG_W'(WDOG_MAX));

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_done_next       = '0;
    w_abort_next      = 1'b0;
    w_cnt_en_next     = r_cnt_en;
    w_cnt_clr_next    = 1'b0;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_wdog_next       = r_wdog;
    w_wdog_err_next   = r_wdog_err;

    case (r_state)
      ST_IDLE: begin
        w_grant_next  = '0;
        w_cnt_en_next = 1'b0;
        if (w_valid) begin
          w_state_next   = ST_LOAD;
          w_grant_next   = w_winner;
          w_owner_next   = onehot_to_idx(w_winner);
          w_cnt_clr_next = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next  = ST_RUN;
        w_cnt_en_next = 1'b1;
        w_wdog_next   = '0;
      end
      ST_RUN: begin
        w_wdog_next = w_wdog_inc;
        // Expiry outranks an abandon or watchdog trip in the same cycle.
        if (bus.timeout_in) begin
          w_state_next      = ST_DONE;
          w_done_next       = r_grant;
          w_grant_next      = '0;
          w_cnt_en_next     = 1'b0;
          w_last_owner_next = r_owner;
        end else if (!bus.req[r_owner] || w_wdog_hit) begin
          w_state_next      = ST_ABORT;
          w_abort_next      = 1'b1;
          w_cnt_clr_next    = 1'b1;
          w_grant_next      = '0;
          w_cnt_en_next     = 1'b0;
          w_last_owner_next = r_owner;
          w_wdog_err_next   = r_wdog_err | w_wdog_hit;
        end
      end
      ST_DONE, ST_ABORT: begin
        w_state_next  = ST_IDLE;
        w_grant_next  = '0;
        w_cnt_en_next = 1'b0;
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_grant_next  = '0;
        w_cnt_en_next = 1'b0;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_abort      <= 1'b0;
      r_cnt_en     <= 1'b0;
      r_cnt_clr    <= 1'b1;
      r_busy       <= 1'b0;
      r_wdog_err   <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= OWN_W'(N_REQ - 1);
      r_wdog       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_done       <= w_done_next;
      r_abort      <= w_abort_next;
      r_cnt_en     <= w_cnt_en_next;
      r_cnt_clr    <= w_cnt_clr_next;
      r_busy       <= w_busy_next;
      r_wdog_err   <= w_wdog_err_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_wdog       <= w_wdog_next;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.done     = r_done;
  assign bus.abort    = r_abort;
  assign bus.cnt_en   = r_cnt_en;
  assign bus.cnt_clr  = r_cnt_clr;
  assign bus.busy     = r_busy;
  assign bus.wdog_err = r_wdog_err;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural count-to-100 counter and
// a grant/done scoreboard filled when requests are driven.
module tb_timer_arbiter;
  import timer_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic to_kill = 1'b0;
  int   cnt = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [N_REQ-1:0] exp_grant_q[$];
  logic [N_REQ-1:0] exp_done_q[$];

  timer_arbiter_if ifc();

  timer_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Shared counter outside the arbiter: clear dominates, counts 0..99 while enabled.
  always @(posedge clk) begin
    if (ifc.cnt_clr) cnt <= 0;
    else if (ifc.cnt_en) cnt <= (cnt == CNT_TERMINAL) ? 0 : cnt + 1;
  end
  assign ifc.timeout_in = !to_kill && (cnt == CNT_TERMINAL);

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_grant"},   32'(ifc.grant),    32'h0);
    check({pfx, "_done"},    32'(ifc.done),     32'h0);
    check({pfx, "_abort"},   32'(ifc.abort),    32'h0);
    check({pfx, "_cnt_en"},  32'(ifc.cnt_en),   32'h0);
    check({pfx, "_cnt_clr"}, 32'(ifc.cnt_clr),  32'h1);
    check({pfx, "_busy"},    32'(ifc.busy),     32'h0);
    check({pfx, "_wdog"},    32'(ifc.wdog_err), 32'h0);
  endtask

  task automatic await_grant(input string tag, output int waited);
    logic [N_REQ-1:0] exp;
    waited = 0;
    while (ifc.grant == '0 && waited < 16) begin
      tick();
      waited++;
    end
    exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : '0;
    check(tag, 32'(ifc.grant), 32'(exp));
    $display("grant %s: grant=%b after %0d cycles", tag, ifc.grant, waited);
  endtask

  task automatic await_done(input string tag, output int en_cycles, output logic to_before);
    logic [N_REQ-1:0] exp;
    en_cycles = 0;
    to_before = 1'b0;
    for (int i = 0; i < 400 && ifc.done == '0; i++) begin
      if (ifc.cnt_en) en_cycles++;
      to_before = ifc.timeout_in;
      tick();
    end
    exp = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : '0;
    check(tag, 32'(ifc.done), 32'(exp));
    $display("done %s: done=%b cnt_en_cycles=%0d", tag, ifc.done, en_cycles);
  endtask

  initial begin
    int   waited;
    int   en_cyc;
    int   n;
    logic to_b;

    ifc.req = '0;
    tick(2);
    check_reset("rst0");
    $display("reset: grant=%b busy=%b cnt_clr=%b", ifc.grant, ifc.busy, ifc.cnt_clr);
    rst = 1'b0;

    // Single requester, full 100-cycle run
    ifc.req = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    await_grant("single_grant", waited);
    check("single_latency", 32'(waited), 32'd1);
    check("single_load_clr", 32'(ifc.cnt_clr), 32'h1);
    await_done("single_done", en_cyc, to_b);
    check("single_en_cycles", 32'(en_cyc), 32'd100);
    check("single_to_before", 32'(to_b), 32'h1);
    check("single_grant_off", 32'(ifc.grant), 32'h0);
    ifc.req = '0;
    tick();
    check("single_done_pulse", 32'(ifc.done), 32'h0);
    check("single_idle_busy", 32'(ifc.busy), 32'h0);

    // Contention from a fresh reset: strict rotation starting at requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_grant_q.push_back(4'b0001 << (i % 4));
      exp_done_q.push_back(4'b0001 << (i % 4));
    end
    for (int i = 0; i < 5; i++) begin
      await_grant("rr_grant", waited);
      check("rr_gap", 32'(waited), (i == 0) ? 32'd1 : 32'd2);
      await_done("rr_done", en_cyc, to_b);
      check("rr_en_cycles", 32'(en_cyc), 32'd100);
      if (i == 4) ifc.req = '0;
    end
    tick();
    check("rr_done_pulse", 32'(ifc.done), 32'h0);

    // Abandon 30 cycles into RUN
    ifc.req = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    await_grant("abandon_grant", waited);
    tick(30);
    check("abandon_running", 32'(ifc.cnt_en), 32'h1);
    ifc.req = '0;
    tick();
    check("abandon_abort", 32'(ifc.abort), 32'h1);
    check("abandon_clr", 32'(ifc.cnt_clr), 32'h1);
    check("abandon_done", 32'(ifc.done), 32'h0);
    check("abandon_grant_off", 32'(ifc.grant), 32'h0);
    tick();
    check("abandon_abort_pulse", 32'(ifc.abort), 32'h0);
    check("abandon_busy", 32'(ifc.busy), 32'h0);
    $display("abandon: abort pulsed, busy=%b", ifc.busy);

    // Timeout and request drop in the same cycle: timeout wins
    ifc.req = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    await_grant("simul_grant", waited);
    n = 0;
    while (!ifc.timeout_in && n < 200) begin
      tick();
      n++;
    end
    ifc.req = '0;
    await_done("simul_done", en_cyc, to_b);
    check("simul_abort", 32'(ifc.abort), 32'h0);
    tick();
    check("simul_abort_after", 32'(ifc.abort), 32'h0);

    // Watchdog with the counter's timeout suppressed
    to_kill = 1'b1;
    ifc.req = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    await_grant("wdog_grant", waited);
    check("wdog_clear_before", 32'(ifc.wdog_err), 32'h0);
    n = 0;
    for (int i = 0; i < 400 && !ifc.abort; i++) begin
      if (ifc.cnt_en) n++;
      tick();
    end
    check("wdog_run_cycles", 32'(n), 32'd120);
    check("wdog_abort", 32'(ifc.abort), 32'h1);
    check("wdog_err_set", 32'(ifc.wdog_err), 32'h1);
    check("wdog_grant_off", 32'(ifc.grant), 32'h0);
    ifc.req = '0;
    tick(5);
    check("wdog_err_sticky", 32'(ifc.wdog_err), 32'h1);
    check("wdog_idle_busy", 32'(ifc.busy), 32'h0);
    $display("watchdog: tripped after %0d RUN cycles", n);
    to_kill = 1'b0;

    // Reset at RUN cycle 50, then requester 0 regains first priority
    ifc.req = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    await_grant("midrst_grant", waited);
    tick(50);
    check("midrst_running", 32'(ifc.cnt_en), 32'h1);
    rst = 1'b1;
    ifc.req = 4'b1001;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    exp_grant_q.push_back(4'b0001);
    await_grant("midrst_regrant", waited);
    check("midrst_latency", 32'(waited), 32'd1);
    ifc.req = '0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
